// File: rtl/servo_pkg.sv
// Shared constants, state encoding and waypoint record
// for the servo waypoint sequencer.
package servo_pkg;

  localparam int MIN_PW    = 70;
  localparam int MAX_PW    = 230;
  localparam int MAX_ANGLE = 180;
  localparam int MAX_SPEED = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MOVE  = 3'd2,
    S_DWELL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] angle;
    logic [3:0] speed;
    logic [7:0] dwell;
  } wp_t;

  function automatic logic [7:0] clamp_angle(
    input logic [7:0] a
  );
    return (a > 8'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : a;
  endfunction

  function automatic logic [3:0] clamp_speed(
    input logic [3:0] s
  );
    if (s == 4'd0) return 4'd1;
    if (s > 4'(MAX_SPEED)) return 4'(MAX_SPEED);
    return s;
  endfunction

endpackage

// File: rtl/servo_wp_table.sv
// Waypoint register file: one write port,
// one asynchronous read port, cleared on reset.
module servo_wp_table
  import servo_pkg::*;
#(
  parameter int N_WP = 8
) (
  input  logic       rotation_clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  wp_t        wr_data,
  input  logic [2:0] rd_addr,
  output wp_t        rd_data
);

  wp_t mem [N_WP];

  // Table storage: clear on reset, else write strobe
  always_ff @(posedge rotation_clk) begin
    if (rst) begin
      for (int i = 0; i < N_WP; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/servo_waypoint_sequencer.sv
// Steps a servo through a table of waypoints,
// mirroring the controller pulsewidth in model_pw.
module servo_waypoint_sequencer #(
  parameter int N_WP   = 8,
  parameter int MIN_PW = servo_pkg::MIN_PW
) (
  input  logic       rotation_clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_angle,
  input  logic [3:0] wr_speed,
  input  logic [7:0] wr_dwell,
  input  logic [2:0] last_idx,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] angle,
  output logic [3:0] speed,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic [2:0] cur_idx
);

  import servo_pkg::*;

  state_t      state;
  state_t      nxt;
  wp_t         entry;
  wp_t         wr_data;
  logic [2:0]  last_q;
  logic [11:0] model_pw;
  logic [11:0] target_pw;
  logic [11:0] diff;
  logic [11:0] spd12;
  logic [11:0] ang12;
  logic [7:0]  dwell_q;
  logic [7:0]  dwell_cnt;
  logic [7:0]  ang_c;
  logic        arrive;
  logic        halt;
  logic        go;

  assign wr_data = {wr_angle, wr_speed, wr_dwell};

  servo_wp_table #(
    .N_WP(N_WP)
  ) u_table (
    .rotation_clk(rotation_clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (cur_idx),
    .rd_data     (entry)
  );

  assign halt  = stop && (state != S_IDLE);
  assign go    = start && !stop;
  assign spd12 = {8'd0, speed};
  assign ang_c = clamp_angle(entry.angle);
  assign ang12 = {4'd0, ang_c};

  // Compare before subtracting so the distance never wraps
  assign diff = (target_pw >= model_pw)
              ? target_pw - model_pw
              : model_pw - target_pw;
  assign arrive = (diff <= spd12);

  // State register
  always_ff @(posedge rotation_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; stop wins over everything but reset
  always_comb begin
    nxt = state;
    if (halt) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (go) nxt = S_FETCH;
        S_FETCH: nxt = S_MOVE;
        S_MOVE:  if (arrive) nxt = S_DWELL;
        S_DWELL: begin
          if (dwell_cnt == 8'd0) begin
            if (cur_idx < last_q) nxt = S_FETCH;
            else if (loop_en)     nxt = S_FETCH;
            else                  nxt = S_DONE;
          end
        end
        S_DONE:  nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: servo outputs, position model, dwell timer
  always_ff @(posedge rotation_clk) begin
    if (rst) begin
      angle     <= '0;
      speed     <= '0;
      en        <= 1'b0;
      cur_idx   <= '0;
      last_q    <= '0;
      model_pw  <= 12'(MIN_PW);
      target_pw <= 12'(MIN_PW);
      dwell_q   <= '0;
      dwell_cnt <= '0;
    end else if (halt) begin
      speed <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            last_q  <= last_idx;
            cur_idx <= '0;
          end
        end
        S_FETCH: begin
          angle     <= ang_c;
          speed     <= clamp_speed(entry.speed);
          en        <= 1'b1;
          target_pw <= (ang12 * 12'd8) / 12'd9
                     + 12'(MIN_PW);
          dwell_q   <= entry.dwell;
        end
        S_MOVE: begin
          if (arrive) begin
            model_pw  <= target_pw;
            dwell_cnt <= dwell_q;
          end else if (target_pw > model_pw) begin
            model_pw <= model_pw + spd12;
          end else begin
            model_pw <= model_pw - spd12;
          end
        end
        S_DWELL: begin
          if (dwell_cnt != 8'd0) begin
            dwell_cnt <= dwell_cnt - 8'd1;
          end else if (cur_idx < last_q) begin
            cur_idx <= cur_idx + 3'd1;
          end else if (loop_en) begin
            cur_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_waypoint_sequencer.sv
// Self-checking bench: per-tick behavioural model
// plus directed scenarios with literal expectations.
module tb_servo_waypoint_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_angle;
  logic [3:0] wr_speed;
  logic [7:0] wr_dwell;
  logic [2:0] last_idx;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [7:0] angle;
  logic [3:0] speed;
  logic       en;
  logic       busy;
  logic       done;
  logic [2:0] cur_idx;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  servo_waypoint_sequencer dut (
    .rotation_clk(clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_angle    (wr_angle),
    .wr_speed    (wr_speed),
    .wr_dwell    (wr_dwell),
    .last_idx    (last_idx),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .angle       (angle),
    .speed       (speed),
    .en          (en),
    .busy        (busy),
    .done        (done),
    .cur_idx     (cur_idx)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 fetch,
  // 2 move, 3 dwell, 4 done
  int ph, m_ang, m_spd, m_en, m_idx, m_last;
  int m_pw, m_tgt, m_cnt, m_dw;
  int t_ang [8];
  int t_spd [8];
  int t_dw  [8];

  always @(posedge clk) begin
    int d;
    if (rst) begin
      ph = 0; m_ang = 0; m_spd = 0; m_en = 0;
      m_idx = 0; m_last = 0; m_pw = 70;
      m_tgt = 70; m_cnt = 0; m_dw = 0;
      for (int i = 0; i < 8; i++) begin
        t_ang[i] = 0; t_spd[i] = 0; t_dw[i] = 0;
      end
    end else begin
      if (stop && ph != 0) begin
        ph = 0;
        m_spd = 0;
      end else begin
        case (ph)
          0: if (start && !stop) begin
            m_last = int'(last_idx);
            m_idx = 0;
            ph = 1;
          end
          1: begin
            m_ang = (t_ang[m_idx] > 180) ? 180 : t_ang[m_idx];
            if (t_spd[m_idx] == 0) m_spd = 1;
            else if (t_spd[m_idx] > 10) m_spd = 10;
            else m_spd = t_spd[m_idx];
            m_en = 1;
            m_tgt = m_ang * 8 / 9 + 70;
            m_dw = t_dw[m_idx];
            ph = 2;
          end
          2: begin
            d = m_tgt - m_pw;
            if (d < 0) d = -d;
            if (d <= m_spd) begin
              m_pw = m_tgt;
              m_cnt = m_dw;
              ph = 3;
            end else if (m_tgt > m_pw) begin
              m_pw = m_pw + m_spd;
            end else begin
              m_pw = m_pw - m_spd;
            end
          end
          3: begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else if (m_idx < m_last) begin
              m_idx = m_idx + 1; ph = 1;
            end else if (loop_en) begin
              m_idx = 0; ph = 1;
            end else ph = 4;
          end
          default: ph = 0;
        endcase
      end
      if (wr_en) begin
        t_ang[wr_addr] = int'(wr_angle);
        t_spd[wr_addr] = int'(wr_speed);
        t_dw[wr_addr]  = int'(wr_dwell);
      end
    end
  end

  // Per-tick comparison of DUT against the model
  always @(negedge clk) begin
    if (chk_on) begin
      tests++;
      if (int'(angle) != m_ang || int'(speed) != m_spd ||
          int'(en) != m_en || int'(cur_idx) != m_idx ||
          busy != (ph != 0) || done != (ph == 4) ||
          int'(dut.model_pw) != m_pw) begin
        fails++;
        $display("FAIL model t=%0t got a=%0d s=%0d en=%0d i=%0d b=%0d d=%0d pw=%0d want a=%0d s=%0d en=%0d i=%0d b=%0d d=%0d pw=%0d",
          $time, angle, speed, en, cur_idx, busy, done,
          dut.model_pw, m_ang, m_spd, m_en, m_idx,
          ph != 0, ph == 4, m_pw);
      end
    end
  end

  task automatic chk(input string nm,
                     input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wp(input int a, input int ang,
                    input int spd, input int dw);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_angle = 8'(ang);
    wr_speed = 4'(spd);
    wr_dwell = 8'(dw);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    int nb, nd, prev;
    int seq[$];
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0;
    wr_angle = '0; wr_speed = '0; wr_dwell = '0;
    last_idx = '0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0;
    cyc(2);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_angle", int'(angle), 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(cur_idx), 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // single waypoint 90 deg, speed 10, dwell 2
    wp(0, 90, 10, 2);
    last_idx = 3'd0;
    go();
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    chk("t1_busy_ticks", nb, 13);
    chk("t1_done_pulses", nd, 1);
    chk("t1_angle", int'(angle), 90);
    chk("t1_speed", int'(speed), 10);
    chk("t1_en", int'(en), 1);
    chk("t1_pw", int'(dut.model_pw), 150);

    // clamping
    wp(0, 200, 15, 0);
    go();
    cyc(1);
    @(negedge clk);
    chk("t2_angle", int'(angle), 180);
    chk("t2_speed", int'(speed), 10);
    cyc(20);
    wp(0, 45, 0, 0);
    go();
    cyc(1);
    @(negedge clk);
    chk("t2_speed_min", int'(speed), 1);
    chk("t2_target", int'(dut.target_pw), 110);
    cyc(140);

    // looping over two entries
    wp(0, 0, 5, 1);
    wp(1, 180, 5, 1);
    last_idx = 3'd1;
    loop_en = 1'b1;
    go();
    prev = -1; nd = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy && int'(cur_idx) != prev) begin
        prev = int'(cur_idx);
        seq.push_back(prev);
      end
      if (seq.size() == 4 && loop_en) loop_en = 1'b0;
      if (!busy && seq.size() >= 4 && nd > 0) break;
    end
    chk("t3_seq_len", seq.size(), 4);
    if (seq.size() == 4) begin
      chk("t3_seq", seq[0]*1000 + seq[1]*100
          + seq[2]*10 + seq[3], 101);
    end
    chk("t3_done", nd, 1);
    chk("t3_idx", int'(cur_idx), 1);

    // stop mid-move, then resume
    wp(0, 0, 10, 0);
    go();
    cyc(4);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    @(negedge clk);
    chk("t4_pw_frozen", int'(dut.model_pw), 200);
    chk("t4_speed", int'(speed), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_en", int'(en), 1);
    cyc(3);
    @(negedge clk);
    chk("t4_pw_hold", int'(dut.model_pw), 200);
    go();
    cyc(2);
    @(negedge clk);
    chk("t4_resume", int'(dut.model_pw), 190);
    cyc(20);

    // start+stop together, then reset in dwell
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    wp(0, 100, 10, 50);
    go();
    cyc(40);
    @(negedge clk);
    chk("t5_in_dwell", int'(busy), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_angle", int'(angle), 0);
    chk("t5_speed", int'(speed), 0);
    chk("t5_en", int'(en), 0);
    chk("t5_busy_r", int'(busy), 0);
    chk("t5_idx", int'(cur_idx), 0);
    chk("t5_pw", int'(dut.model_pw), 70);
    go();
    cyc(1);
    @(negedge clk);
    chk("t5_tbl_speed", int'(speed), 1);
    chk("t5_tbl_angle", int'(angle), 0);
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
